// File: rtl/muldiv_arbiter.sv
// muldiv_arbiter: round-robin front end that shares one MulDiv unit between
// the core E stage (requester 0) and an auxiliary port (requester 1).
// Each accepted op is issued to the unit, its busy period is waited out
// (bounded by TIMEOUT), and exactly one response goes back to the owner.
module muldiv_arbiter #(
   parameter logic [2:0] SEL_LO   = 3'd0,
   parameter logic [2:0] SEL_HI   = 3'd1,
   parameter logic [2:0] SEL_MUL  = 3'd2,
   parameter logic [2:0] SEL_MULU = 3'd3,
   parameter logic [2:0] SEL_DIV  = 3'd4,
   parameter logic [2:0] SEL_DIVU = 3'd5,
   parameter logic [2:0] SEL_IDLE = 3'd7,
   parameter int         TIMEOUT  = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  req_valid,
   output logic [1:0]  req_ready,
   input  logic [2:0]  req0_op,
   input  logic [31:0] req0_a,
   input  logic [31:0] req0_b,
   input  logic [2:0]  req1_op,
   input  logic [31:0] req1_a,
   input  logic [31:0] req1_b,
   output logic [1:0]  rsp_valid,
   output logic [31:0] rsp_data,
   output logic        rsp_err,
   output logic        err_sticky,
   output logic        md_start,
   output logic        md_we,
   output logic [2:0]  md_sel,
   output logic [31:0] md_a,
   output logic [31:0] md_b,
   input  logic        md_busy,
   input  logic [31:0] md_c
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   typedef enum logic [2:0] {
      OP_MFLO = 3'd0,
      OP_MFHI = 3'd1,
      OP_MUL  = 3'd2,
      OP_MULU = 3'd3,
      OP_DIV  = 3'd4,
      OP_DIVU = 3'd5,
      OP_MTLO = 3'd6,
      OP_MTHI = 3'd7
   } op_t;

   state_t           state;
   state_t           state_nxt;
   logic [1:0]       grant;
   logic             last_grant;
   logic             owner;
   op_t              op;
   logic [31:0]      op_a;
   logic [31:0]      op_b;
   logic [31:0]      rdata;
   logic [CNT_W-1:0] cnt;
   logic             abort;
   logic [2:0]       op_sel;
   logic             is_compute;
   logic             is_mf;
   logic             is_mt;
   logic             timeout_hit;

   // Last permitted WAIT cycle with the unit still busy ends the op as aborted.
   assign timeout_hit = md_busy && (cnt == CNT_W'(TIMEOUT - 1));

   // Decode the latched op into its unit sel code and op class.
   always_comb begin
      op_sel     = SEL_IDLE;
      is_compute = 1'b0;
      is_mf      = 1'b0;
      is_mt      = 1'b0;
      unique case (op)
         OP_MFLO: begin op_sel = SEL_LO;   is_mf = 1'b1;      end
         OP_MFHI: begin op_sel = SEL_HI;   is_mf = 1'b1;      end
         OP_MUL:  begin op_sel = SEL_MUL;  is_compute = 1'b1; end
         OP_MULU: begin op_sel = SEL_MULU; is_compute = 1'b1; end
         OP_DIV:  begin op_sel = SEL_DIV;  is_compute = 1'b1; end
         OP_DIVU: begin op_sel = SEL_DIVU; is_compute = 1'b1; end
         OP_MTLO: begin op_sel = SEL_LO;   is_mt = 1'b1;      end
         OP_MTHI: begin op_sel = SEL_HI;   is_mt = 1'b1;      end
      endcase
   end

   // Round-robin grant, only offered while idle; a lone requester always wins.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first so no path infers a latch.
      grant = 2'b00;
      if (state == S_IDLE) begin
         unique case (req_valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant ? 2'b01 : 2'b10;
            default: grant = 2'b00;
         endcase
      end
   end

   assign req_ready = grant;

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
      if (!rst) state <= S_IDLE;
      else      state <= state_nxt;
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE:  if (grant != 2'b00) state_nxt = S_ISSUE;
         S_ISSUE: state_nxt = is_compute ? S_WAIT : S_RESP;
         S_WAIT:  if (!md_busy || timeout_hit) state_nxt = S_RESP;
         S_RESP:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Unit pins and response outputs, decoded from the current state.
   always_comb begin
      md_start  = 1'b0;
      md_we     = 1'b0;
      md_sel    = SEL_IDLE;
      md_a      = '0;
      md_b      = '0;
      rsp_valid = 2'b00;
      rsp_data  = '0;
      rsp_err   = 1'b0;
      unique case (state)
         S_ISSUE: begin
            md_a     = op_a;
            md_b     = op_b;
            md_sel   = op_sel;
            md_start = is_compute;
            md_we    = is_mt;
         end
         S_WAIT: md_sel = op_sel;
         S_RESP: begin
            rsp_valid = owner ? 2'b10 : 2'b01;
            rsp_data  = rdata;
            rsp_err   = abort;
         end
         default: ;
      endcase
   end

   // Request latch, MF* read capture, wait counter and error flags.
   always_ff @(posedge clk or negedge rst) begin
      // NOTE: the op/operand/data registers are reset as well so an op in flight is fully dropped.
      if (!rst) begin
         last_grant <= 1'b1;
         owner      <= 1'b0;
         op         <= OP_MFLO;
         op_a       <= '0;
         op_b       <= '0;
         rdata      <= '0;
         cnt        <= '0;
         abort      <= 1'b0;
         err_sticky <= 1'b0;
      end else begin
         if (grant != 2'b00) begin
            owner      <= grant[1];
            last_grant <= grant[1];
            op         <= grant[1] ? op_t'(req1_op) : op_t'(req0_op);
            op_a       <= grant[1] ? req1_a : req0_a;
            op_b       <= grant[1] ? req1_b : req0_b;
            rdata      <= '0;
         end
         if (state == S_ISSUE && is_mf) rdata <= md_c;
         if (state == S_WAIT) begin
            cnt <= cnt + 1'b1;
            if (timeout_hit) begin
               abort      <= 1'b1;
               err_sticky <= 1'b1;
            end
         end
         if (state == S_RESP) begin
            cnt   <= '0;
            abort <= 1'b0;
         end
      end
   end

endmodule
